// File: rtl/jtframe_rom_pkg.sv
// Shared types and helpers for the N-slot SDRAM ROM arbiter.
// - state_t  : arbiter FSM states
// - DW*      : per-slot data width codes
// - slot_offset / slot_dw : unpack the per-slot packed parameters
package jtframe_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] DW8  = 2'd0;
    localparam logic [1:0] DW16 = 2'd1;
    localparam logic [1:0] DW32 = 2'd2;

    localparam int MAX_SLOTS = 16;

    // Packed parameters are zero-extended to MAX_SLOTS entries by the caller.
    function automatic logic [21:0] slot_offset(input logic [22*MAX_SLOTS-1:0] offs, input int i);
        return offs[22*i +: 22];
    endfunction

    function automatic logic [1:0] slot_dw(input logic [2*MAX_SLOTS-1:0] codes, input int i);
        return codes[2*i +: 2];
    endfunction

endpackage

// File: rtl/jtframe_rom_cache.sv
// One-entry 32-bit cache for a single ROM slot.
// - clr          : drop the valid bit (download / loop reset)
// - wr, wr_tag, wr_data : fill from the SDRAM
// - addr, cs, dw : client byte address, request, width code
// - ok           : cs & valid & tag match (combinational, zero latency)
// - dout         : selected byte/halfword/word, right-aligned, upper bits zero
module jtframe_rom_cache
    import jtframe_rom_pkg::*;
#(
    parameter int AW = 18
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [AW-3:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic [1:0]    dw,
    output logic          ok,
    output logic [31:0]   dout
);

    logic          valid;
    logic [AW-3:0] tag;
    logic [31:0]   data;

    // Tag and data are still written when clr coincides with a fill; only
    // the valid bit is suppressed so the entry never reports a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (wr) begin
                tag  <= wr_tag;
                data <= wr_data;
            end
            if (clr)     valid <= 1'b0;
            else if (wr) valid <= 1'b1;
        end
    end

    assign ok = cs & valid & (tag == addr[AW-1:2]);

    always_comb begin
        dout = '0;
        case (dw)
            DW8:     dout[7:0]  = data[{addr[1:0], 3'b000} +: 8];
            DW16:    dout[15:0] = addr[1] ? data[31:16] : data[15:0];
            default: dout       = data;
        endcase
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// N-slot SDRAM ROM arbiter with per-slot one-word caches.
// - clk, rst            : clock, synchronous active-high reset
// - vblank              : enables the VB_SLOT priority boost
// - downloading         : aborts transfers, clears caches, halts arbitration
// - loop_rst            : clears all caches
// - slot_cs/addr/ok/dout: client side, packed per slot
// - sdram_req/ack/addr  : request handshake to the SDRAM controller
// - data_rdy/data_read  : one-cycle read data return {word+1, word}
// - refresh_en          : idle with no outstanding miss
module jtframe_rom_arb
    import jtframe_rom_pkg::*;
#(
    parameter int                  SLOTS   = 5,
    parameter int                  AW      = 18,
    parameter logic [22*SLOTS-1:0] OFFSET  = {SLOTS{22'd0}},
    parameter logic [2*SLOTS-1:0]  DWCODE  = {SLOTS{2'd0}},
    parameter int                  RR      = 1,
    parameter int                  VB_SLOT = -1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                vblank,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    output logic [21:0]         sdram_addr,
    input  logic [31:0]         data_read,
    output logic                refresh_en
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [22*MAX_SLOTS-1:0] OFF_EXT = (22*MAX_SLOTS)'(OFFSET);
    localparam logic [2*MAX_SLOTS-1:0]  DW_EXT  = (2*MAX_SLOTS)'(DWCODE);
    localparam bit VB_EN  = (VB_SLOT >= 0) && (VB_SLOT < SLOTS);
    localparam int VB_IDX = VB_EN ? VB_SLOT : 0;

    state_t         state, nxt;
    logic [SLOTS-1:0] miss, wr;
    logic [IW-1:0]  win_idx, rr_ptr, grant_idx;
    logic [AW-3:0]  win_tag;
    logic           grant_vld, grant, fill;
    logic [21:0]    waddr [SLOTS];
    logic [AW-3:0]  tags  [SLOTS];
    logic           clr;

    assign clr  = downloading | loop_rst;
    assign miss = slot_cs & ~slot_ok;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign tags[g]  = slot_addr[g*AW+2 +: AW-2];
        // Word-pair address in 16-bit SDRAM words; the sum wraps at 22 bits.
        assign waddr[g] = slot_offset(OFF_EXT, g) + 22'({tags[g], 1'b0});
        assign wr[g]    = fill & (win_idx == IW'(g));

        jtframe_rom_cache #(.AW(AW)) u_cache (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .wr      (wr[g]),
            .wr_tag  (win_tag),
            .wr_data (data_read),
            .addr    (slot_addr[g*AW +: AW]),
            .cs      (slot_cs[g]),
            .dw      (slot_dw(DW_EXT, g)),
            .ok      (slot_ok[g]),
            .dout    (slot_dout[g*32 +: 32])
        );
    end

    // Winner among missing slots: vblank boost first, then RR or fixed order.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (VB_EN && vblank && miss[VB_IDX]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(VB_IDX);
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                idx = (RR != 0) ? (int'(rr_ptr) + k) % SLOTS : k;
                if (!grant_vld && miss[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = IW'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (grant)     nxt = REQ;
            REQ:     if (sdram_ack) nxt = WAIT;
            WAIT:    if (data_rdy)  nxt = IDLE;
            default:                nxt = IDLE;
        endcase
        if (downloading) nxt = IDLE;
    end

    always_comb begin
        grant      = (state == IDLE) & grant_vld & ~downloading;
        fill       = (state == WAIT) & data_rdy & ~downloading;
        sdram_req  = (state == REQ);
        refresh_en = (state == IDLE) & ~|miss;
    end

    // Grant latch: the fill always uses the tag captured here, even if the
    // client moves on before the data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_idx    <= '0;
            win_tag    <= '0;
            sdram_addr <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            win_idx    <= grant_idx;
            win_tag    <= tags[grant_idx];
            sdram_addr <= waddr[grant_idx];
            rr_ptr     <= (grant_idx == IW'(SLOTS-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
module tb_jtframe_rom_arb;

    localparam int S  = 3;
    localparam int AW = 18;
    localparam logic [22*S-1:0] OFFS = {22'h3F_FFF0, 22'h01_4000, 22'h00_0100};
    localparam logic [2*S-1:0]  DWC  = {2'd2, 2'd1, 2'd0};

    logic clk = 1'b0;
    logic rst = 1'b1, vblank = 1'b0, downloading = 1'b0, loop_rst = 1'b0;

    logic [S-1:0]    a_cs = '0, b_cs = '0, a_ok, b_ok;
    logic [S*AW-1:0] a_addr = '0, b_addr = '0;
    logic [S*32-1:0] a_dout, b_dout;
    logic            a_req, b_req, a_ack = 1'b0, b_ack = 1'b0, a_rdy = 1'b0, b_rdy = 1'b0;
    logic [21:0]     a_saddr, b_saddr;
    logic [31:0]     a_data = '0, b_data = '0;
    logic            a_ref, b_ref;

    always #5 clk = ~clk;

    jtframe_rom_arb #(.SLOTS(S), .AW(AW), .OFFSET(OFFS), .DWCODE(DWC), .RR(1), .VB_SLOT(2)) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(a_cs), .slot_addr(a_addr), .slot_ok(a_ok), .slot_dout(a_dout),
        .sdram_req(a_req), .sdram_ack(a_ack), .data_rdy(a_rdy), .sdram_addr(a_saddr),
        .data_read(a_data), .refresh_en(a_ref));

    jtframe_rom_arb #(.SLOTS(S), .AW(AW), .OFFSET(OFFS), .DWCODE(DWC), .RR(0), .VB_SLOT(-1)) dut_fp (
        .clk(clk), .rst(rst), .vblank(vblank), .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(b_cs), .slot_addr(b_addr), .slot_ok(b_ok), .slot_dout(b_dout),
        .sdram_req(b_req), .sdram_ack(b_ack), .data_rdy(b_rdy), .sdram_addr(b_saddr),
        .data_read(b_data), .refresh_en(b_ref));

    int n_cmp = 0, n_bad = 0;

    // Reference model (random phase): per-slot cache contents and RR start.
    logic [21:0] off_m [S] = '{22'h00_0100, 22'h01_4000, 22'h3F_FFF0};
    int          dw_m  [S] = '{8, 16, 32};
    bit          mv    [S];
    logic [15:0] mtag  [S];
    logic [31:0] mdat  [S];
    logic [17:0] ra    [S];
    int          rr_next;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] exp_sa(input int i, input logic [17:0] a);
        return off_m[i] + (22'(a[17:2]) << 1);
    endfunction

    function automatic logic [31:0] exp_dout(input int i, input logic [31:0] d, input logic [17:0] a);
        logic [31:0] sh;
        if (dw_m[i] == 8) begin
            sh = d >> (8 * a[1:0]);
            return sh & 32'hFF;
        end else if (dw_m[i] == 16) begin
            sh = a[1] ? (d >> 16) : d;
            return sh & 32'hFFFF;
        end
        return d;
    endfunction

    task automatic set_addr(input bit b, input int i, input logic [17:0] a);
        if (b) b_addr[i*AW +: AW] = a;
        else   a_addr[i*AW +: AW] = a;
    endtask

    task automatic wait_req(input bit b, input logic [21:0] exp, input string tag);
        int n = 0;
        while (!(b ? b_req : a_req) && n < 20) begin tick(); n++; end
        chk({tag, "_req"}, b ? b_req : a_req, 1'b1);
        chk({tag, "_addr"}, b ? b_saddr : a_saddr, exp);
    endtask

    task automatic do_ack(input bit b);
        if (b) b_ack = 1'b1; else a_ack = 1'b1;
        tick();
        a_ack = 1'b0; b_ack = 1'b0;
    endtask

    task automatic do_rdy(input bit b, input logic [31:0] d);
        if (b) begin b_data = d; b_rdy = 1'b1; end
        else   begin a_data = d; a_rdy = 1'b1; end
        tick();
        a_rdy = 1'b0; b_rdy = 1'b0;
    endtask

    task automatic serve(input bit b, input logic [21:0] exp, input logic [31:0] d, input string tag);
        wait_req(b, exp, tag);
        do_ack(b);
        chk({tag, "_req_drop"}, b ? b_req : a_req, 1'b0);
        do_rdy(b, d);
    endtask

    task automatic rst_pulse();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        logic [17:0] rb0;
        logic [S-1:0] eok, pend;
        logic [31:0] d;
        int w;

        tick(); tick(); rst = 1'b0;

        // Reset state
        chk("rst_ok", a_ok, 3'b000);
        chk("rst_dout", a_dout, '0);
        chk("rst_req", a_req, 1'b0);
        chk("rst_saddr", a_saddr, 22'h0);
        chk("rst_refresh", a_ref, 1'b1);

        // Hit path, 8-bit slot
        set_addr(0, 0, 18'h5); a_cs[0] = 1'b1;
        serve(0, 22'h102, 32'hAABBCCDD, "hit");
        chk("hit_ok", a_ok[0], 1'b1);
        chk("hit_dout", a_dout[31:0], 32'hCC);
        set_addr(0, 0, 18'h6); #1;
        chk("hit2_ok", a_ok[0], 1'b1);
        chk("hit2_dout", a_dout[31:0], 32'hBB);
        tick();
        chk("hit2_noreq", a_req, 1'b0);
        a_cs = '0;

        // 16-bit slot with offset
        set_addr(0, 1, 18'h102); a_cs[1] = 1'b1;
        serve(0, 22'h1_4080, 32'h12345678, "w16");
        chk("w16_ok", a_ok[1], 1'b1);
        chk("w16_dout", a_dout[63:32], 32'h1234);
        a_cs = '0;

        // Round-robin: every slot keeps missing
        rst_pulse();
        ra[0] = 18'h000; ra[1] = 18'h200; ra[2] = 18'h400;
        for (int i = 0; i < S; i++) set_addr(0, i, ra[i]);
        a_cs = 3'b111;
        for (int k = 0; k < 6; k++) begin
            w = k % S;
            serve(0, exp_sa(w, ra[w]), 32'(k), "rr");
            ra[w] = ra[w] + 18'd4;
            set_addr(0, w, ra[w]);
        end
        a_cs = '0;

        // Vblank boost
        rst_pulse();
        set_addr(0, 0, 18'h40); set_addr(0, 2, 18'h40); a_cs = 3'b101;
        serve(0, 22'h120, 32'h1, "vb_off");
        set_addr(0, 0, 18'h80); set_addr(0, 1, 18'h80); a_cs = 3'b111; vblank = 1'b1;
        serve(0, 22'h00_0010, 32'h2, "vb_on");
        vblank = 1'b0;
        serve(0, 22'h140, 32'h3, "vb_after0");
        serve(0, 22'h1_4040, 32'h4, "vb_after1");
        chk("vb_allok", a_ok, 3'b111);
        chk("vb_refresh", a_ref, 1'b1);

        // Download abort in WAIT, then a stale data_rdy
        set_addr(0, 1, 18'h84);
        wait_req(0, 22'h1_4042, "dl");
        do_ack(0);
        downloading = 1'b1; tick();
        chk("dl_req", a_req, 1'b0);
        chk("dl_ok", a_ok, 3'b000);
        downloading = 1'b0; a_cs = '0;
        do_rdy(0, 32'hDEADBEEF);
        a_cs = 3'b111; #1;
        chk("dl_stale_ok", a_ok, 3'b000);
        a_cs = '0;

        // Address change while the fill is in flight
        set_addr(0, 0, 18'h10); a_cs[0] = 1'b1;
        wait_req(0, 22'h108, "mid");
        do_ack(0);
        set_addr(0, 0, 18'h20);
        do_rdy(0, 32'h11223344);
        chk("mid_ok", a_ok[0], 1'b0);
        serve(0, 22'h110, 32'h55667788, "mid_re");
        chk("mid_re_ok", a_ok[0], 1'b1);
        chk("mid_re_dout", a_dout[31:0], 32'h88);
        a_cs = '0;

        // loop_rst coinciding with the fill
        set_addr(0, 2, 18'h100); a_cs[2] = 1'b1;
        wait_req(0, 22'h00_0070, "lr");
        do_ack(0);
        loop_rst = 1'b1;
        do_rdy(0, 32'h0BADF00D);
        loop_rst = 1'b0;
        chk("lr_ok", a_ok[2], 1'b0);
        serve(0, 22'h00_0070, 32'hCAFEF00D, "lr_re");
        chk("lr_re_ok", a_ok[2], 1'b1);
        chk("lr_re_dout", a_dout[95:64], 32'hCAFEF00D);
        a_cs = '0;

        // Fixed priority instance: slot0 wins while it keeps missing
        rst_pulse();
        rb0 = 18'h0;
        set_addr(1, 0, rb0); set_addr(1, 1, 18'h200); set_addr(1, 2, 18'h400);
        b_cs = 3'b111;
        for (int k = 0; k < 3; k++) begin
            serve(1, exp_sa(0, rb0), 32'(k), "fp0");
            if (k < 2) begin rb0 = rb0 + 18'd4; set_addr(1, 0, rb0); end
        end
        serve(1, exp_sa(1, 18'h200), 32'h5, "fp1");
        serve(1, exp_sa(2, 18'h400), 32'h6, "fp2");
        chk("fp_allok", b_ok, 3'b111);
        b_cs = '0; #1;
        chk("fp_refresh", b_ref, 1'b1);

        // Randomized traffic against the reference model
        rst_pulse();
        rr_next = 0;
        for (int i = 0; i < S; i++) begin mv[i] = 1'b0; mtag[i] = '0; mdat[i] = '0; end
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < S; i++) begin
                ra[i] = 18'($urandom_range(0, 31));
                if ($urandom_range(0, 7) == 0) ra[i] = ra[i] | 18'h3_0000;
                set_addr(0, i, ra[i]);
                a_cs[i] = ($urandom_range(0, 3) != 0);
            end
            vblank = ($urandom_range(0, 3) == 0);
            #1;
            for (int i = 0; i < S; i++) begin
                eok[i] = a_cs[i] & mv[i] & (mtag[i] == ra[i][17:2]);
                chk("rnd_dout", a_dout[i*32 +: 32], exp_dout(i, mdat[i], ra[i]));
            end
            chk("rnd_ok", a_ok, eok);
            pend = a_cs & ~eok;
            chk("rnd_refresh", a_ref, pend == '0);
            if (pend != '0) begin
                w = -1;
                if (vblank && pend[2]) w = 2;
                for (int k = 0; k < S; k++)
                    if (w < 0 && pend[(rr_next + k) % S]) w = (rr_next + k) % S;
                d = $urandom;
                serve(0, exp_sa(w, ra[w]), d, "rnd");
                mv[w] = 1'b1; mtag[w] = ra[w][17:2]; mdat[w] = d;
                rr_next = (w + 1) % S;
            end else begin
                tick();
                chk("rnd_noreq", a_req, 1'b0);
            end
        end
        a_cs = '0; vblank = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
